// File: rtl/mask_imm_pkg.sv
// Shared types and constants for the split logic-immediate mask decoder.
package mask_imm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic [5:0]  EMPTY_LOW  = 6'd63;
  localparam logic [5:0]  EMPTY_HIGH = 6'd0;
  localparam int unsigned HALF_W     = 32;

  typedef struct packed {
    logic       seen_one;
    logic       gap;
    logic       bad;
    logic [5:0] low;
    logic [5:0] high;
  } half_track_t;

  // Starting tracker: an untouched half already carries the canonical empty encoding.
  localparam half_track_t TRACK_INIT = '{
    seen_one: 1'b0,
    gap:      1'b0,
    bad:      1'b0,
    low:      EMPTY_LOW,
    high:     EMPTY_HIGH
  };

endpackage

// File: rtl/mask_chunk_scan.sv
// Folds one CHUNK-wide slice of the mask into a half tracker, LSB first.
module mask_chunk_scan
  import mask_imm_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  half_track_t      trk_i,
  input  logic [CHUNK-1:0] bits_i,
  input  logic [5:0]       base_i,
  output half_track_t      trk_o
);

  always_comb begin
    trk_o = trk_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (bits_i[i]) begin
        if (!trk_o.seen_one) begin
          trk_o.low = base_i + 6'(i);
        end
        trk_o.high = base_i + 6'(i);
        if (trk_o.gap) begin
          trk_o.bad = 1'b1;
        end
        trk_o.seen_one = 1'b1;
      end else if (trk_o.seen_one) begin
        trk_o.gap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mask_imm_decoder.sv
// Serial decoder recovering per-half low/high selects and legality from a 64-bit mask.
module mask_imm_decoder
  import mask_imm_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_low_bot,
  output logic [5:0]  out_high_bot,
  output logic [5:0]  out_low_top,
  output logic [5:0]  out_high_top,
  output logic        out_empty_bot,
  output logic        out_empty_top,
  output logic        out_legal
);

  localparam int unsigned NCHUNK = 64 / CHUNK;
  localparam int unsigned CNT_W  = $clog2(NCHUNK);
  localparam int unsigned LAST   = NCHUNK - 1;

  state_e            state_q, state_d;
  logic [63:0]       mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  half_track_t       bot_q, bot_d, top_q, top_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        low_bot_q, low_bot_d, high_bot_q, high_bot_d;
  logic [5:0]        low_top_q, low_top_d, high_top_q, high_top_d;
  logic              empty_bot_q, empty_bot_d, empty_top_q, empty_top_d;
  logic              legal_q, legal_d;

  logic              top_sel_c;
  logic [5:0]        base_c;
  half_track_t       trk_sel_c, trk_upd_c;

  // Counter MSB marks the top half since no chunk straddles bit 32.
  assign top_sel_c = cnt_q[CNT_W-1];
  assign base_c    = 6'(32'(cnt_q) * CHUNK);
  assign trk_sel_c = top_sel_c ? top_q : bot_q;

  mask_chunk_scan #(.CHUNK(CHUNK)) u_scan (
    .trk_i  (trk_sel_c),
    .bits_i (mask_q[CHUNK-1:0]),
    .base_i (base_c),
    .trk_o  (trk_upd_c)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    bot_d       = bot_q;
    top_d       = top_q;
    low_bot_d   = low_bot_q;
    high_bot_d  = high_bot_q;
    low_top_d   = low_top_q;
    high_top_d  = high_top_q;
    empty_bot_d = empty_bot_q;
    empty_top_d = empty_top_q;
    legal_d     = legal_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mask_d  = in_mask;
          cnt_d   = '0;
          bot_d   = TRACK_INIT;
          top_d   = TRACK_INIT;
          state_d = SCAN;
        end
      end
      SCAN: begin
        mask_d = mask_q >> CHUNK;
        cnt_d  = cnt_q + 1'b1;
        if (top_sel_c) begin
          top_d = trk_upd_c;
        end else begin
          bot_d = trk_upd_c;
        end
        // The final chunk is always top half, so take it straight from the scanner.
        if (cnt_q == CNT_W'(LAST)) begin
          low_bot_d   = bot_q.low;
          high_bot_d  = bot_q.high;
          empty_bot_d = !bot_q.seen_one;
          low_top_d   = trk_upd_c.low;
          high_top_d  = trk_upd_c.high;
          empty_top_d = !trk_upd_c.seen_one;
          legal_d     = !bot_q.bad && !trk_upd_c.bad;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      bot_q       <= TRACK_INIT;
      top_q       <= TRACK_INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      low_bot_q   <= '0;
      high_bot_q  <= '0;
      low_top_q   <= '0;
      high_top_q  <= '0;
      empty_bot_q <= 1'b0;
      empty_top_q <= 1'b0;
      legal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      bot_q       <= bot_d;
      top_q       <= top_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      low_bot_q   <= low_bot_d;
      high_bot_q  <= high_bot_d;
      low_top_q   <= low_top_d;
      high_top_q  <= high_top_d;
      empty_bot_q <= empty_bot_d;
      empty_top_q <= empty_top_d;
      legal_q     <= legal_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_low_bot   = low_bot_q;
  assign out_high_bot  = high_bot_q;
  assign out_low_top   = low_top_q;
  assign out_high_top  = high_top_q;
  assign out_empty_bot = empty_bot_q;
  assign out_empty_top = empty_top_q;
  assign out_legal     = legal_q;

endmodule

// File: doc/mask_imm_decoder.md
Name: mask_imm_decoder

Overview:
- Inverse of the 64-bit split logic-immediate mask generator.
- Accepts a 64-bit mask and recovers four 6-bit selects: LowMaskSel/HighMaskSel for the bottom half (bits 31:0) and the top half (bits 63:32).
- Also flags whether the mask is legal, i.e. each half is empty or one contiguous run of ones.
- Scans the mask serially, CHUNK bits per cycle, with valid/ready on both the input and output sides.

Parameters:
- CHUNK, 8, bits examined per SCAN cycle; must be a power of two dividing 32 (legal values 1, 2, 4, 8, 16, 32).
- NCHUNK, 64/CHUNK, derived; number of SCAN cycles; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_mask is valid
- in_ready  out  1  decoder idle, can accept a mask
- in_mask  in  64  mask to decode
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_low_bot  out  6  lowest set bit index in bits 31:0
- out_high_bot  out  6  highest set bit index in bits 31:0
- out_low_top  out  6  lowest set bit index in bits 63:32 (absolute, 32..63)
- out_high_top  out  6  highest set bit index in bits 63:32 (absolute)
- out_empty_bot  out  1  bits 31:0 all zero
- out_empty_top  out  1  bits 63:32 all zero
- out_legal  out  1  each half is empty or one contiguous run

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - FSM goes to IDLE; in_ready=1 from the first cycle after rst deasserts.
  - out_valid=0, all index outputs 0, all flags 0.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_mask into a shift register, clear the chunk counter and all per-half tracker state, then go to SCAN.
- SCAN:
  - Each cycle examine mask bits [k*CHUNK +: CHUNK], where k is the chunk counter (0..NCHUNK-1), LSB first.
  - Per-half tracker holds: seen_one, gap (a zero seen after a one), bad (a one seen after a gap), low, high.
  - First set bit sets low. Every set bit updates high. A set bit with gap=1 sets bad.
  - Within a chunk, resolve left-to-right over the bits combinationally.
  - Chunk index k=NCHUNK/2 starts the top half; top-half tracker state is independent of the bottom half. No chunk straddles bit 32.
  - After chunk NCHUNK-1 is consumed, register the results, go to DONE, and assert out_valid.
  - Latency: out_valid rises exactly NCHUNK cycles after the input handshake cycle (8 for CHUNK=8).
- DONE:
  - out_valid=1, in_ready=0; all outputs stable.
  - On out_valid&&out_ready, go to IDLE. out_valid drops the next cycle and in_ready rises the same cycle.
  - No input is accepted on the handshake cycle itself, so throughput is at most one mask per NCHUNK+1 cycles.
- Empty half uses a canonical encoding chosen so the generator reproduces all-zero for that half:
  - low=6'd63, high=6'd0, empty flag=1.
- out_legal = !bad_bot && !bad_top.
- Illegal masks: low and high still report the lowest and highest set bit of each half.
- Round-trip property: for a legal mask, feeding (low_bot, high_bot, low_top, high_top) to the mask generator reproduces in_mask bit-exactly.
- in_mask is sampled only at the handshake; changes at any other time are ignored.
- out_ready asserted while not DONE is ignored.
- rst mid-SCAN or mid-DONE aborts the operation; the pending result is discarded, never presented.

Decomposition:
- Package mask_imm_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - localparams EMPTY_LOW=6'd63, EMPTY_HIGH=6'd0, HALF_W=32
  - packed struct half_track_t {seen_one, gap, bad, low[5:0], high[5:0]}
- One combinational sub-module, mask_chunk_scan:
  - Inputs: half_track_t, CHUNK bits, base index.
  - Output: the updated half_track_t.
  - Instantiated once; the top level selects the bottom or top tracker register by chunk counter MSB.

Test Plan:
1. in_mask=64'h0 -> at cycle 8 (CHUNK=8): out_empty_bot=out_empty_top=1, low_bot=low_top=63, high_bot=high_top=0, out_legal=1.
2. in_mask=64'h0000_00F0_0000_0FF0 -> low_bot=4, high_bot=11, low_top=36, high_top=39, legal=1; re-encoding through the generator matches.
3. in_mask=64'hFFFF_FFFF_FFFF_FFFF -> low_bot=0, high_bot=31, low_top=32, high_top=63, legal=1; also 64'h8000_0001_0000_0000 -> top half illegal (bits 32 and 63), low_top=32, high_top=63, legal=0, empty_bot=1.
4. in_mask=64'h0000_0000_0000_0005 -> low_bot=0, high_bot=2, legal=0, empty_top=1.
5. Hold out_ready=0 for 5 cycles after out_valid -> outputs and out_valid stable, in_ready=0; then out_ready=1 -> in_ready=1 the next cycle, and a second mask is accepted and completes after a further 8 cycles.
6. Assert rst on the 3rd SCAN cycle -> out_valid never rises for that mask; in_ready=1 the cycle after rst drops; a new mask decodes correctly. Repeat cases 1-4 with CHUNK=1 and CHUNK=32 for the same results at latency 64 and 2.
